// File: rtl/run_perf_monitor_pkg.sv
// Shared types for the run-control / performance-monitor block: FSM state
// encoding and the enable decode used by the run-control sequencer.
package run_perf_monitor_pkg;

   typedef enum logic [1:0] {
      RUN_ST_RUN  = 2'b00,
      RUN_ST_HALT = 2'b01,
      RUN_ST_STEP = 2'b10
   } run_st_e;

   function automatic logic run_st_en(input run_st_e st);
      return (st == RUN_ST_RUN) || (st == RUN_ST_STEP);
   endfunction

endpackage

// File: rtl/run_perf_monitor_if.sv
// Board-side bundle of the monitor: run-control buttons, event strobes,
// counter control and the counter read port.
interface run_perf_monitor_if #(
   parameter int NumEvt = 4,
   parameter int SelBit = 2,
   parameter int CntBit = 32
);
   import run_perf_monitor_pkg::*;

   logic              resume;
   logic              step;
   logic              halt;
   logic [NumEvt-1:0] evt;
   logic              clr;
   logic              snap;
   logic [SelBit-1:0] sel;
   logic              sel_snap;
   logic              en;
   run_st_e           run_st;
   logic [CntBit-1:0] rd_data;
   logic [NumEvt-1:0] ovf;

   modport master (
      output resume, step, halt, evt, clr, snap, sel, sel_snap,
      input  en, run_st, rd_data, ovf
   );

   modport slave (
      input  resume, step, halt, evt, clr, snap, sel, sel_snap,
      output en, run_st, rd_data, ovf
   );

endinterface

// File: rtl/run_perf_monitor_ctrl.sv
// Run-control sequencer: synchronises the resume/step buttons, detects their
// rising edges and gates the core enable through the RUN/HALT/STEP machine.
module run_perf_monitor_ctrl
   import run_perf_monitor_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    resume,
   input  logic    step,
   input  logic    halt,
   output logic    en,
   output run_st_e run_st
);

   logic [1:0] resume_sync_q, resume_sync_d;
   logic [1:0] step_sync_q, step_sync_d;
   logic       resume_prev_q, resume_prev_d;
   logic       step_prev_q, step_prev_d;
   logic       resume_edge, step_edge;
   run_st_e    state_q, state_d;
   logic       en_q, en_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resume_sync_q <= '0;
         step_sync_q   <= '0;
         resume_prev_q <= 1'b0;
         step_prev_q   <= 1'b0;
         state_q       <= RUN_ST_RUN;
         en_q          <= 1'b1;
      end else begin
         resume_sync_q <= resume_sync_d;
         step_sync_q   <= step_sync_d;
         resume_prev_q <= resume_prev_d;
         step_prev_q   <= step_prev_d;
         state_q       <= state_d;
         en_q          <= en_d;
      end
   end

   always_comb begin
      resume_sync_d = {resume_sync_q[0], resume};
      step_sync_d   = {step_sync_q[0], step};
      resume_prev_d = resume_sync_q[1];
      step_prev_d   = step_sync_q[1];
      resume_edge   = resume_sync_q[1] & ~resume_prev_q;
      step_edge     = step_sync_q[1] & ~step_prev_q;
      state_d       = state_q;

      // Button edges only matter while halted; resume beats step.
      case (state_q)
         RUN_ST_RUN:  if (halt) state_d = RUN_ST_HALT;
         RUN_ST_HALT: begin
            if (resume_edge)    state_d = RUN_ST_RUN;
            else if (step_edge) state_d = RUN_ST_STEP;
         end
         RUN_ST_STEP: state_d = RUN_ST_HALT;
         default:     state_d = RUN_ST_HALT;
      endcase

      en_d = run_st_en(state_d);
   end

   assign en     = en_q;
   assign run_st = state_q;

endmodule

// File: rtl/run_perf_monitor.sv
// Run-control and performance monitor: gates the core enable and counts event
// strobes while enabled, with snapshot registers and a counter read mux.
module run_perf_monitor
   import run_perf_monitor_pkg::*;
#(
   parameter int NumEvt  = 4,
   parameter int SelBit  = 2,
   parameter int CntBit  = 32,
   parameter int SatMode = 0
) (
   input logic               clk,
   input logic               rst,
   run_perf_monitor_if.slave bus
);

   localparam logic [CntBit-1:0] CntMax = '1;

   logic              en_w;
   run_st_e           run_st_w;
   logic [SelBit-1:0] sel_w;
   logic [CntBit-1:0] live_arr [NumEvt];
   logic [CntBit-1:0] snap_arr [NumEvt];
   logic [NumEvt-1:0] ovf_w;
   logic [CntBit-1:0] rd_data_w;

   run_perf_monitor_ctrl u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .resume (bus.resume),
      .step   (bus.step),
      .halt   (bus.halt),
      .en     (en_w),
      .run_st (run_st_w)
   );

   for (genvar gi = 0; gi < NumEvt; gi++) begin : g_cnt
      logic [CntBit-1:0] cnt_q, cnt_d;
      logic [CntBit-1:0] snap_q, snap_d;
      logic              ovf_q, ovf_d;

      always_comb begin
         cnt_d  = cnt_q;
         ovf_d  = ovf_q;
         // Snapshot samples the pre-edge value, so snap+clr keeps the old count.
         snap_d = bus.snap ? cnt_q : snap_q;
         if (bus.clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
         end else if (en_w && bus.evt[gi]) begin
            if (cnt_q == CntMax) begin
               ovf_d = 1'b1;
               if (SatMode == 0) cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q  <= '0;
            snap_q <= '0;
            ovf_q  <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            ovf_q  <= ovf_d;
         end
      end

      assign live_arr[gi] = cnt_q;
      assign snap_arr[gi] = snap_q;
      assign ovf_w[gi]    = ovf_q;
   end

   assign sel_w = bus.sel;

   // Indices past the last counter read as zero.
   always_comb begin
      rd_data_w = '0;
      for (int i = 0; i < NumEvt; i++) begin
         if (int'(sel_w) == i) rd_data_w = bus.sel_snap ? snap_arr[i] : live_arr[i];
      end
   end

   assign bus.en      = en_w;
   assign bus.run_st  = run_st_w;
   assign bus.rd_data = rd_data_w;
   assign bus.ovf     = ovf_w;

endmodule

// File: tb/tb_run_perf_monitor.sv
// Scoreboard bench: stimulus pushes expected values, a negedge monitor pops
// and compares them against the three monitor instances.
module tb_run_perf_monitor;
   import run_perf_monitor_pkg::*;

   localparam int S_EN   = 0;
   localparam int S_ST   = 1;
   localparam int S_RD0  = 2;
   localparam int S_OVF0 = 3;
   localparam int S_WRD  = 4;
   localparam int S_WOVF = 5;
   localparam int S_SRD  = 6;
   localparam int S_SOVF = 7;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   run_perf_monitor_if #(.NumEvt(4), .SelBit(2), .CntBit(32)) bus0 ();
   run_perf_monitor_if #(.NumEvt(3), .SelBit(2), .CntBit(4))  bus_w ();
   run_perf_monitor_if #(.NumEvt(3), .SelBit(2), .CntBit(4))  bus_s ();

   run_perf_monitor #(.NumEvt(4), .SelBit(2), .CntBit(32), .SatMode(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0)
   );
   run_perf_monitor #(.NumEvt(3), .SelBit(2), .CntBit(4), .SatMode(0)) dut_w (
      .clk(clk), .rst(rst), .bus(bus_w)
   );
   run_perf_monitor #(.NumEvt(3), .SelBit(2), .CntBit(4), .SatMode(1)) dut_s (
      .clk(clk), .rst(rst), .bus(bus_s)
   );

   // Both small instances see identical stimulus.
   logic [2:0] s_evt;
   logic       s_clr;
   logic [1:0] s_sel;
   assign bus_w.resume = 1'b0;  assign bus_s.resume = 1'b0;
   assign bus_w.step = 1'b0;    assign bus_s.step = 1'b0;
   assign bus_w.halt = 1'b0;    assign bus_s.halt = 1'b0;
   assign bus_w.snap = 1'b0;    assign bus_s.snap = 1'b0;
   assign bus_w.sel_snap = 1'b0; assign bus_s.sel_snap = 1'b0;
   assign bus_w.evt = s_evt;    assign bus_s.evt = s_evt;
   assign bus_w.clr = s_clr;    assign bus_s.clr = s_clr;
   assign bus_w.sel = s_sel;    assign bus_s.sel = s_sel;

   int          exp_src_q[$];
   logic [31:0] exp_val_q[$];
   string       exp_name_q[$];
   int          checks = 0;
   int          failures = 0;

   task automatic expect_val(input int src, input logic [31:0] val, input string nm);
      exp_src_q.push_back(src);
      exp_val_q.push_back(val);
      exp_name_q.push_back(nm);
   endtask

   function automatic logic [31:0] observe(input int src);
      case (src)
         S_EN:    return {31'b0, bus0.en};
         S_ST:    return {30'b0, bus0.run_st};
         S_RD0:   return bus0.rd_data;
         S_OVF0:  return {28'b0, bus0.ovf};
         S_WRD:   return {28'b0, bus_w.rd_data};
         S_WOVF:  return {29'b0, bus_w.ovf};
         S_SRD:   return {28'b0, bus_s.rd_data};
         S_SOVF:  return {29'b0, bus_s.ovf};
         default: return '1;
      endcase
   endfunction

   always @(negedge clk) begin
      int          src;
      logic [31:0] exp_v;
      logic [31:0] act;
      string       nm;
      while (exp_src_q.size() != 0) begin
         src   = exp_src_q.pop_front();
         exp_v = exp_val_q.pop_front();
         nm    = exp_name_q.pop_front();
         act   = observe(src);
         checks++;
         if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
         end else begin
            $display("check %s: %0d ok", nm, act);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_chk(input logic [1:0] sel, input logic ss, input logic [31:0] v,
                           input string nm);
      bus0.sel      = sel;
      bus0.sel_snap = ss;
      expect_val(S_RD0, v, nm);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      bus0.resume = 1'b0; bus0.step = 1'b0; bus0.halt = 1'b0; bus0.evt = '0;
      bus0.clr = 1'b0; bus0.snap = 1'b0; bus0.sel = '0; bus0.sel_snap = 1'b0;
      s_evt = '0; s_clr = 1'b0; s_sel = '0;

      tick();
      expect_val(S_EN, 1, "rst_en");
      expect_val(S_ST, 0, "rst_st");
      expect_val(S_RD0, 0, "rst_rd");
      expect_val(S_OVF0, 0, "rst_ovf");
      tick();
      rst = 1'b0;

      // Ten events on counter 0 while running
      bus0.evt = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         expect_val(S_EN, 1, "run_en");
         tick();
      end
      bus0.evt = 4'b0000;
      expect_val(S_RD0, 10, "cnt_10");
      expect_val(S_OVF0, 0, "ovf_clear");
      tick();

      // Halt: the halting cycle still counts, then frozen
      bus0.evt = 4'b0001;
      bus0.halt = 1'b1;
      expect_val(S_EN, 1, "halt_cycle_en");
      tick();
      bus0.halt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expect_val(S_EN, 0, "halted_en");
         expect_val(S_ST, 1, "halted_st");
         tick();
      end
      bus0.evt = 4'b0000;
      expect_val(S_RD0, 11, "frozen_cnt");

      // Resume: en rises after the third edge sampling the pulse
      bus0.resume = 1'b1;
      expect_val(S_EN, 0, "resume_lat0");
      tick();
      bus0.resume = 1'b0;
      expect_val(S_EN, 0, "resume_lat1");
      tick();
      expect_val(S_EN, 0, "resume_lat2");
      tick();
      expect_val(S_EN, 1, "resume_en");
      expect_val(S_ST, 0, "resume_st");
      tick();

      // Halt again, then three single steps with evt[0] held
      bus0.halt = 1'b1;
      tick();
      bus0.halt = 1'b0;
      bus0.evt = 4'b0001;
      for (int p = 0; p < 3; p++) begin
         bus0.step = 1'b1;
         for (int k = 0; k < 10; k++) begin
            expect_val(S_EN, (k == 3) ? 32'd1 : 32'd0, "step_en");
            if (k == 3) expect_val(S_ST, 2, "step_st");
            tick();
            if (k == 0) bus0.step = 1'b0;
         end
      end
      bus0.evt = 4'b0000;
      expect_val(S_RD0, 14, "step_cnt");
      tick();

      // Step and resume edges together -> RUN
      bus0.step = 1'b1;
      bus0.resume = 1'b1;
      tick();
      bus0.step = 1'b0;
      bus0.resume = 1'b0;
      tick();
      tick();
      expect_val(S_EN, 1, "both_en");
      expect_val(S_ST, 0, "both_st");
      tick();
      expect_val(S_EN, 1, "both_en_hold");
      expect_val(S_ST, 0, "both_st_hold");
      tick();

      // Counter 2 to 7, snap+clr together, then 5 more events
      bus0.evt = 4'b0100;
      repeat (7) tick();
      bus0.evt = 4'b0101;
      bus0.snap = 1'b1;
      bus0.clr = 1'b1;
      tick();
      bus0.snap = 1'b0;
      bus0.clr = 1'b0;
      bus0.evt = 4'b0100;
      repeat (5) tick();
      bus0.evt = 4'b0000;
      read_chk(2'd2, 1'b1, 7, "snap_cnt2");
      read_chk(2'd2, 1'b0, 5, "live_cnt2");
      read_chk(2'd0, 1'b1, 14, "snap_cnt0");
      read_chk(2'd0, 1'b0, 0, "live_cnt0_clr");
      read_chk(2'd1, 1'b1, 0, "snap_cnt1");
      read_chk(2'd3, 1'b0, 0, "live_cnt3");

      // Reset while in STEP with resume held
      bus0.sel = 2'd0;
      bus0.sel_snap = 1'b0;
      bus0.halt = 1'b1;
      tick();
      bus0.halt = 1'b0;
      bus0.evt = 4'b0001;
      bus0.step = 1'b1;
      tick();
      bus0.step = 1'b0;
      tick();
      tick();
      expect_val(S_EN, 1, "pre_rst_step_en");
      expect_val(S_ST, 2, "pre_rst_step_st");
      tick();
      bus0.resume = 1'b1;
      bus0.evt = 4'b0000;
      rst = 1'b1;
      expect_val(S_EN, 1, "mid_rst_en");
      expect_val(S_ST, 0, "mid_rst_st");
      read_chk(2'd2, 1'b0, 0, "rst_live_cnt2");
      read_chk(2'd2, 1'b1, 0, "rst_snap_cnt2");
      bus0.sel = 2'd0;
      bus0.sel_snap = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         expect_val(S_EN, 1, "post_rst_en");
         expect_val(S_ST, 0, "post_rst_st");
         tick();
      end
      bus0.halt = 1'b1;
      tick();
      bus0.halt = 1'b0;
      for (int i = 0; i < 6; i++) begin
         expect_val(S_EN, 0, "held_resume_no_edge");
         tick();
      end
      bus0.resume = 1'b0;

      // 4-bit counters: 17 events on counters 0 and 1
      s_evt = 3'b011;
      repeat (17) tick();
      s_evt = 3'b000;
      s_sel = 2'd1;
      expect_val(S_WRD, 1, "wrap_rd");
      expect_val(S_WOVF, 3, "wrap_ovf");
      expect_val(S_SRD, 15, "sat_rd");
      expect_val(S_SOVF, 3, "sat_ovf");
      tick();
      s_sel = 2'd0;
      expect_val(S_WRD, 1, "wrap_rd0");
      expect_val(S_SRD, 15, "sat_rd0");
      tick();
      s_sel = 2'd3;
      expect_val(S_WRD, 0, "wrap_sel_oob");
      expect_val(S_SRD, 0, "sat_sel_oob");
      tick();
      s_clr = 1'b1;
      tick();
      s_clr = 1'b0;
      s_sel = 2'd1;
      expect_val(S_WRD, 0, "wrap_clr_rd");
      expect_val(S_WOVF, 0, "wrap_clr_ovf");
      expect_val(S_SRD, 0, "sat_clr_rd");
      expect_val(S_SOVF, 0, "sat_clr_ovf");
      tick();
      tick();

      if (exp_src_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_src_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
